mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: state sequencer, ALU decode,
// condition check against the stored NZCV flags, and per-state control outputs.
module mc_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic        ALUSrcA,
   output logic        MOVFlag,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [2:0]  ALUControl,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_ex_q, cond_ex_d;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       unused_rn;

   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign funct     = Instr[13:8];
   assign rd        = Instr[3:0];
   assign unused_rn = ^Instr[7:4];

   logic cond_ex;
   logic flag_n, flag_z, flag_c, flag_v;
   assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = (flag_n == flag_v);
         4'b1011: cond_ex = (flag_n != flag_v);
         4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_ex = flag_z | (flag_n != flag_v);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Unrecognised data-processing commands behave as a non-writing ADD.
   logic [2:0] alu_dec_ctrl;
   logic       no_write;
   logic       is_mov;

   always_comb begin
      alu_dec_ctrl = 3'b000;
      no_write     = 1'b0;
      is_mov       = 1'b0;
      case (funct[4:1])
         4'b0100: alu_dec_ctrl = 3'b000;
         4'b0010: alu_dec_ctrl = 3'b001;
         4'b0000: alu_dec_ctrl = 3'b010;
         4'b1100: alu_dec_ctrl = 3'b011;
         4'b0001: alu_dec_ctrl = 3'b100;
         4'b1010: begin alu_dec_ctrl = 3'b001; no_write = 1'b1; end
         4'b1000: begin alu_dec_ctrl = 3'b010; no_write = 1'b1; end
         4'b1101: begin alu_dec_ctrl = 3'b000; is_mov   = 1'b1; end
         default: begin alu_dec_ctrl = 3'b000; no_write = 1'b1; end
      endcase
   end

   logic in_exec;
   assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

   always_comb begin
      state_d   = S_FETCH;
      flags_d   = flags_q;
      cond_ex_d = cond_ex;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR:  state_d = S_ALUWB;
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
      // C and V only carry meaning for the adder/subtractor operations.
      if (in_exec && funct[0] && cond_ex) begin
         flags_d[3:2] = ALUFlags[3:2];
         if (alu_dec_ctrl == 3'b000 || alu_dec_ctrl == 3'b001)
            flags_d[1:0] = ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         flags_q   <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end

   // Outputs decode only the state register, so reset forces FETCH values at once.
   logic rd_is_pc;
   assign rd_is_pc = (rd == 4'hF);

   always_comb begin
      PCWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      MOVFlag    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 3'b000;
      RegSrc     = 2'b00;
      ImmSrc     = 2'b00;
      case (op)
         2'b01:   begin RegSrc = 2'b10; ImmSrc = 2'b01; end
         2'b10:   begin RegSrc = 2'b01; ImmSrc = 2'b10; end
         default: begin RegSrc = 2'b00; ImmSrc = 2'b00; end
      endcase
      case (state_q)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_MEMADR: ALUSrcB = 2'b01;
         S_MEMRD:  AdrSrc  = 1'b1;
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = cond_ex_q;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = cond_ex_q;
            PCWrite   = cond_ex_q & rd_is_pc;
         end
         S_EXECR: begin
            ALUControl = alu_dec_ctrl;
            MOVFlag    = is_mov;
         end
         S_EXECI: begin
            ALUSrcB    = 2'b01;
            ALUControl = alu_dec_ctrl;
            MOVFlag    = is_mov;
         end
         S_ALUWB: begin
            RegWrite = cond_ex_q & ~no_write;
            PCWrite  = cond_ex_q & ~no_write & rd_is_pc;
            MOVFlag  = is_mov;
         end
         S_BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            PCWrite   = cond_ex_q;
         end
         default: ;
      endcase
   end

   assign State = state_q;

endmodule
